// File: rtl/dtm_jtag.sv
// RISC-V JTAG debug transport: oversampled TAP driving a single-outstanding
// DMI master port. All JTAG pins are sampled in the clk domain.
module dtm_jtag #(
   parameter logic [31:0] IDCODE      = 32'h1000_0001,
   parameter int          ABITS       = 7,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             jtag_tck,
   input  logic             jtag_tms,
   input  logic             jtag_tdi,
   output logic             jtag_tdo,
   output logic             dmi_valid,
   input  logic             dmi_ready,
   output logic             dmi_write,
   output logic [ABITS-1:0] dmi_addr,
   output logic [31:0]      dmi_wdata,
   input  logic [31:0]      dmi_rdata
);

   localparam int DW = ABITS + 34;
   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;
   localparam logic [5:0] ABITS6    = 6'(ABITS);

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
   } tap_e;

   logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
   logic                   tck_prev_q;
   tap_e                   tap_q, tap_d;
   logic [4:0]             ir_q, ir_d;
   logic [DW-1:0]          sr_q, sr_d;
   logic                   tdo_q, tdo_d;
   logic                   valid_q, valid_d;
   logic                   write_q, write_d;
   logic [ABITS-1:0]       addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            data_q, data_d;
   logic [1:0]             stat_q, stat_d;

   logic tck_s, tms_s, tdi_s;
   logic tck_rise, tck_fall;
   logic hs, busy;
   logic [1:0]  op_st;
   logic [31:0] dtmcs_w;

   assign tck_s    = tck_sync_q[SYNC_STAGES-1];
   assign tms_s    = tms_sync_q[SYNC_STAGES-1];
   assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
   assign tck_rise = tck_s & ~tck_prev_q;
   assign tck_fall = ~tck_s & tck_prev_q;

   // A handshake in this cycle frees the port for an update in the same cycle.
   assign hs    = valid_q & dmi_ready;
   assign busy  = valid_q & ~dmi_ready;
   assign op_st = (valid_q || stat_q != 2'd0) ? 2'd3 : 2'd0;
   assign dtmcs_w = {14'b0, 3'b000, 3'd1, stat_q, ABITS6, 4'd1};

   always_comb begin
      tap_d = tap_q;
      if (tck_rise) begin
         unique case (tap_q)
            TLR:    tap_d = tms_s ? TLR    : RTI;
            RTI:    tap_d = tms_s ? SEL_DR : RTI;
            SEL_DR: tap_d = tms_s ? SEL_IR : CAP_DR;
            CAP_DR: tap_d = tms_s ? EX1_DR : SH_DR;
            SH_DR:  tap_d = tms_s ? EX1_DR : SH_DR;
            EX1_DR: tap_d = tms_s ? UPD_DR : PA_DR;
            PA_DR:  tap_d = tms_s ? EX2_DR : PA_DR;
            EX2_DR: tap_d = tms_s ? UPD_DR : SH_DR;
            UPD_DR: tap_d = tms_s ? SEL_DR : RTI;
            SEL_IR: tap_d = tms_s ? TLR    : CAP_IR;
            CAP_IR: tap_d = tms_s ? EX1_IR : SH_IR;
            SH_IR:  tap_d = tms_s ? EX1_IR : SH_IR;
            EX1_IR: tap_d = tms_s ? UPD_IR : PA_IR;
            PA_IR:  tap_d = tms_s ? EX2_IR : PA_IR;
            EX2_IR: tap_d = tms_s ? UPD_IR : SH_IR;
            UPD_IR: tap_d = tms_s ? SEL_DR : RTI;
         endcase
      end
   end

   always_comb begin
      ir_d    = ir_q;
      sr_d    = sr_q;
      tdo_d   = tdo_q;
      valid_d = valid_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      stat_d  = stat_q;

      if (hs) begin
         valid_d = 1'b0;
         if (!write_q) data_d = dmi_rdata;
      end

      if (tck_rise) begin
         case (tap_q)
            CAP_IR: sr_d = {{(DW-5){1'b0}}, 5'b00001};
            SH_IR:  sr_d = {{(DW-5){1'b0}}, tdi_s, sr_q[4:1]};
            CAP_DR: begin
               case (ir_q)
                  IR_IDCODE: sr_d = {{(DW-32){1'b0}}, IDCODE};
                  IR_DTMCS:  sr_d = {{(DW-32){1'b0}}, dtmcs_w};
                  IR_DMI: begin
                     sr_d = {addr_q, data_q, op_st};
                     if (valid_q) stat_d = 2'd3;
                  end
                  default:   sr_d = '0;
               endcase
            end
            SH_DR: begin
               case (ir_q)
                  IR_IDCODE,
                  IR_DTMCS: sr_d = {{(DW-32){1'b0}}, tdi_s, sr_q[31:1]};
                  IR_DMI:   sr_d = {tdi_s, sr_q[DW-1:1]};
                  default:  sr_d = {{(DW-1){1'b0}}, tdi_s};
               endcase
            end
            default: ;
         endcase
      end

      if (tck_fall) begin
         case (tap_q)
            SH_IR, SH_DR: tdo_d = sr_q[0];
            UPD_IR:       ir_d  = sr_q[4:0];
            UPD_DR: begin
               if (ir_q == IR_DTMCS) begin
                  if (sr_q[16] || sr_q[17]) stat_d = 2'd0;
                  if (sr_q[17]) begin
                     valid_d = 1'b0;
                     data_d  = data_q;
                  end
               end else if (ir_q == IR_DMI) begin
                  if (busy) begin
                     stat_d = 2'd3;
                  end else if (stat_q == 2'd0) begin
                     addr_d  = sr_q[DW-1:34];
                     wdata_d = sr_q[33:2];
                     if (sr_q[1:0] == 2'd1) begin
                        valid_d = 1'b1;
                        write_d = 1'b0;
                     end else if (sr_q[1:0] == 2'd2) begin
                        valid_d = 1'b1;
                        write_d = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      if (tap_q == TLR) ir_d = IR_IDCODE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tck_sync_q <= '0;
         tms_sync_q <= '0;
         tdi_sync_q <= '0;
         tck_prev_q <= 1'b0;
         tap_q      <= TLR;
         ir_q       <= IR_IDCODE;
         sr_q       <= '0;
         tdo_q      <= 1'b0;
         valid_q    <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         data_q     <= '0;
         stat_q     <= 2'd0;
      end else begin
         tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], jtag_tck};
         tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], jtag_tms};
         tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], jtag_tdi};
         tck_prev_q <= tck_s;
         tap_q      <= tap_d;
         ir_q       <= ir_d;
         sr_q       <= sr_d;
         tdo_q      <= tdo_d;
         valid_q    <= valid_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         data_q     <= data_d;
         stat_q     <= stat_d;
      end
   end

   assign jtag_tdo  = tdo_q;
   assign dmi_valid = valid_q;
   assign dmi_write = write_q;
   assign dmi_addr  = addr_q;
   assign dmi_wdata = wdata_q;

endmodule

// File: tb/tb_dtm_jtag.sv
// Bench for dtm_jtag: JTAG scans driven from tasks, a DMI slave model,
// and scoreboards for scan-out data and DMI requests.
module tb_dtm_jtag;

   localparam int ABITS = 7;
   localparam int DW = ABITS + 34;
   localparam logic [31:0] IDC = 32'h1000_0001;
   localparam int H = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic jtag_tck = 1'b0;
   logic jtag_tms = 1'b1;
   logic jtag_tdi = 1'b0;
   logic jtag_tdo;
   logic dmi_valid;
   logic dmi_ready = 1'b0;
   logic dmi_write;
   logic [ABITS-1:0] dmi_addr;
   logic [31:0] dmi_wdata;
   logic [31:0] dmi_rdata = 32'h0;

   dtm_jtag #(.IDCODE(IDC), .ABITS(ABITS), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
      .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
      .dmi_valid(dmi_valid), .dmi_ready(dmi_ready),
      .dmi_write(dmi_write), .dmi_addr(dmi_addr),
      .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             w;
      logic [ABITS-1:0] a;
      logic [31:0]      d;
   } req_t;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] sexp_q[$];
   logic [DW-1:0] smask_q[$];
   logic [DW-1:0] sobs_q[$];
   string         sname_q[$];
   req_t          rexp_q[$];

   logic [31:0] smem[128];
   bit slave_en = 1'b1;
   int dly = 2;

   // reference model state
   logic [31:0] mmem[128];
   logic [1:0]  m_stat;
   logic [31:0] m_data;
   bit          m_out;
   bit          m_prd;
   logic [6:0]  m_pa;
   logic [31:0] m_pd;

   function automatic logic [31:0] init_val(int a);
      return 32'hA5A5_0000 ^ (32'(a) * 32'h0001_0203);
   endfunction

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   // DMI slave: random accept latency, memory-backed reads
   always begin
      @(posedge clk);
      #2;
      if (dmi_ready) begin
         dmi_ready = 1'b0;
      end else if (slave_en && dmi_valid) begin
         if (dly <= 0) begin
            dmi_ready = 1'b1;
            dmi_rdata = smem[dmi_addr];
            if (dmi_write) smem[dmi_addr] = dmi_wdata;
            dly = $urandom_range(0, 3);
         end else begin
            dly--;
         end
      end
   end

   // scan-out monitor
   logic [DW-1:0] mo, me, mm;
   string mn;
   always @(negedge clk) begin
      while (sobs_q.size() > 0) begin
         mo = sobs_q.pop_front();
         if (sexp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scan_unexpected actual=%h required=none", mo);
         end else begin
            me = sexp_q.pop_front();
            mm = smask_q.pop_front();
            mn = sname_q.pop_front();
            chk(mn, 64'(mo & mm), 64'(me));
         end
      end
   end

   // DMI request monitor
   req_t pr, rr;
   bit pv = 1'b0;
   bit phs = 1'b0;
   always @(negedge clk) begin
      if (phs) chk("valid_after_hs", 64'(dmi_valid), 64'd0);
      if (pv && !phs && dmi_valid)
         chk("req_hold", 64'({dmi_write, dmi_addr, dmi_wdata}), 64'(pr));
      if (dmi_valid && dmi_ready) begin
         if (rexp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected actual=%h required=none",
                     {dmi_write, dmi_addr, dmi_wdata});
         end else begin
            rr = rexp_q.pop_front();
            chk("req_write", 64'(dmi_write), 64'(rr.w));
            chk("req_addr", 64'(dmi_addr), 64'(rr.a));
            if (rr.w) chk("req_wdata", 64'(dmi_wdata), 64'(rr.d));
         end
      end
      pv  = dmi_valid;
      phs = dmi_valid && dmi_ready;
      pr  = {dmi_write, dmi_addr, dmi_wdata};
   end

   task automatic tck1(input logic tms, input logic tdi, output logic tdo);
      jtag_tms = tms;
      jtag_tdi = tdi;
      repeat (H) @(posedge clk);
      #1;
      tdo = jtag_tdo;
      jtag_tck = 1'b1;
      repeat (H) @(posedge clk);
      #1;
      jtag_tck = 1'b0;
   endtask

   // from Run-Test/Idle, through one IR or DR scan, back to Run-Test/Idle
   task automatic scan(input bit ir, input int len, input logic [DW-1:0] din,
                       input logic [DW-1:0] e, input logic [DW-1:0] m,
                       input string n);
      logic [DW-1:0] o;
      logic b;
      o = '0;
      sexp_q.push_back(e & m);
      smask_q.push_back(m);
      sname_q.push_back(n);
      tck1(1'b1, 1'b0, b);
      if (ir) tck1(1'b1, 1'b0, b);
      tck1(1'b0, 1'b0, b);
      tck1(1'b0, 1'b0, b);
      for (int i = 0; i < len; i++) begin
         tck1(logic'(i == len - 1), din[i], b);
         o[i] = b;
      end
      tck1(1'b1, 1'b0, b);
      tck1(1'b0, 1'b0, b);
      sobs_q.push_back(o);
   endtask

   task automatic set_ir(input logic [4:0] v);
      scan(1'b1, 5, DW'(v), DW'(5'b00001), DW'(5'h1f), "ir_capture");
   endtask

   function automatic logic [31:0] dtmcs_exp();
      return {14'b0, 3'b000, 3'd1, m_stat, 6'(ABITS), 4'd1};
   endfunction

   task automatic dtmcs(input logic [31:0] din, input string n);
      scan(1'b0, 32, DW'(din), DW'(dtmcs_exp()), DW'(32'hFFFF_FFFF), n);
   endtask

   task automatic dmi(input logic [6:0] a, input logic [31:0] d,
                      input logic [1:0] op, input string n);
      logic [1:0] st;
      logic [DW-1:0] e;
      req_t r;
      st = (m_stat != 2'd0 || m_out) ? 2'd3 : 2'd0;
      e = {7'b0, m_data, st};
      if (m_out) begin
         m_stat = 2'd3;
      end else if (m_stat == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
         m_out = 1'b1;
         m_prd = (op == 2'd1);
         m_pa = a;
         m_pd = d;
         r.w = (op == 2'd2);
         r.a = a;
         r.d = d;
         rexp_q.push_back(r);
      end
      scan(1'b0, DW, {a, d, op}, e, {7'b0, {34{1'b1}}}, n);
   endtask

   task automatic wait_done(input string n);
      int k;
      if (!m_out) return;
      k = 0;
      while (rexp_q.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(n, 64'(rexp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      if (m_prd) m_data = mmem[m_pa];
      else mmem[m_pa] = m_pd;
      m_out = 1'b0;
   endtask

   task automatic wait_valid(input string n);
      int k;
      k = 0;
      while (!dmi_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(n, 64'(dmi_valid), 64'd1);
   endtask

   task automatic model_reset();
      m_stat = 2'd0;
      m_data = 32'h0;
      m_out = 1'b0;
      m_prd = 1'b0;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic b;
      int r;
      logic [6:0] ra;
      logic [31:0] rd;
      for (int i = 0; i < 128; i++) begin
         smem[i] = init_val(i);
         mmem[i] = init_val(i);
      end
      model_reset();

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(dmi_valid), 64'd0);
      chk("rst_write", 64'(dmi_write), 64'd0);
      chk("rst_addr", 64'(dmi_addr), 64'd0);
      chk("rst_wdata", 64'(dmi_wdata), 64'd0);
      chk("rst_tdo", 64'(jtag_tdo), 64'd0);
      reset = 1'b0;

      repeat (5) tck1(1'b1, 1'b0, b);
      tck1(1'b0, 1'b0, b);
      scan(1'b0, 32, '0, DW'(IDC), DW'(32'hFFFF_FFFF), "idcode");

      set_ir(5'h10);
      dtmcs(32'h0, "dtmcs_reset");

      set_ir(5'h1f);
      scan(1'b0, 3, DW'(3'b101), DW'(3'b010), DW'(3'b111), "bypass");

      set_ir(5'h11);
      dly = 2;
      dmi(7'h10, 32'h1, 2'd2, "wr_capture");
      wait_done("wr_done");
      smem[7'h11] = 32'h0000_0C82;
      mmem[7'h11] = 32'h0000_0C82;
      dmi(7'h11, 32'h0, 2'd1, "rd_capture");
      wait_done("rd_done");
      dmi(7'h00, 32'h0, 2'd0, "rd_data");

      // sticky busy
      slave_en = 1'b0;
      dmi(7'h05, 32'hDEAD_BEEF, 2'd2, "busy_first");
      wait_valid("busy_valid");
      dmi(7'h06, 32'h1234_5678, 2'd2, "busy_second");
      set_ir(5'h10);
      dtmcs(32'h0, "dtmcs_sticky");
      dtmcs(32'h0001_0000, "dtmcs_sticky2");
      m_stat = 2'd0;
      dtmcs(32'h0, "dtmcs_cleared");
      slave_en = 1'b1;
      wait_done("busy_done");
      set_ir(5'h11);
      dmi(7'h00, 32'h0, 2'd0, "busy_after");

      // dmihardreset abandons the outstanding read
      slave_en = 1'b0;
      dmi(7'h22, 32'h0, 2'd1, "hr_capture");
      wait_valid("hr_valid");
      set_ir(5'h10);
      dtmcs(32'h0002_0000, "hr_dtmcs");
      void'(rexp_q.pop_back());
      m_stat = 2'd0;
      m_out = 1'b0;
      repeat (2) @(negedge clk);
      chk("hr_drop", 64'(dmi_valid), 64'd0);
      slave_en = 1'b1;
      repeat (20) @(negedge clk);

      // Test-Logic-Reset does not cancel the handshake
      set_ir(5'h11);
      slave_en = 1'b0;
      dmi(7'h07, 32'h0, 2'd1, "tlr_capture");
      wait_valid("tlr_valid");
      repeat (5) tck1(1'b1, 1'b0, b);
      chk("tlr_keep", 64'(dmi_valid), 64'd1);
      tck1(1'b0, 1'b0, b);
      slave_en = 1'b1;
      wait_done("tlr_done");
      scan(1'b0, 32, '0, DW'(IDC), DW'(32'hFFFF_FFFF), "tlr_idcode");
      set_ir(5'h11);
      dmi(7'h00, 32'h0, 2'd0, "tlr_data");

      for (int t = 0; t < 24; t++) begin
         r = $urandom_range(0, 9);
         ra = 7'($urandom_range(0, 15));
         rd = $urandom;
         if (r < 4) dmi(ra, rd, 2'd2, "rnd_wr");
         else if (r < 8) dmi(ra, rd, 2'd1, "rnd_rd");
         else if (r == 8) dmi(ra, rd, 2'd0, "rnd_nop");
         else dmi(ra, rd, 2'd3, "rnd_op3");
         wait_done("rnd_done");
      end
      dmi(7'h00, 32'h0, 2'd0, "rnd_last");

      // reset in the middle of a transaction
      slave_en = 1'b0;
      dmi(7'h33, 32'h0, 2'd1, "rst_capture");
      wait_valid("rst_mid_valid");
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_valid0", 64'(dmi_valid), 64'd0);
      chk("rst_mid_tdo", 64'(jtag_tdo), 64'd0);
      chk("rst_mid_addr", 64'(dmi_addr), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rexp_q.delete();
      model_reset();
      slave_en = 1'b1;
      tck1(1'b0, 1'b0, b);
      scan(1'b0, 32, '0, DW'(IDC), DW'(32'hFFFF_FFFF), "rst_idcode");
      set_ir(5'h11);
      dmi(7'h00, 32'h0, 2'd0, "rst_data");

      repeat (10) @(negedge clk);
      chk("scan_left", 64'(sexp_q.size()), 64'd0);
      chk("req_left", 64'(rexp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
